// File: rtl/popcount_pattern_gen.sv
// rtl/popcount_pattern_gen.sv - emits every WIDTH-bit word with a requested ones count, ascending
// Optional macro PATGEN_FASTSKIP_EN: direct next-combination step instead of linear scan.
`timescale 1ns/1ps
module popcount_pattern_gen #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_ones,
    output logic             req_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [WIDTH-1:0] out_index,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state_q;
    logic [CW-1:0]    target_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] cand_d;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] last_pat;
    logic             req_ready_q, req_err_q, out_valid_q, out_last_q, busy_q;
    logic [WIDTH-1:0] out_data_q, out_index_q;

    function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] x);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + CW'(x[i]);
        return n;
    endfunction

    // The final word of a sequence has all k ones packed into the top bits.
    assign last_pat = ~(ALL_ONES >> target_q);

`ifdef PATGEN_FASTSKIP_EN
    logic [WIDTH-1:0] lowbit, ripple;
    logic [CW-1:0]    ctz;
    logic             found;

    assign seed = ~(ALL_ONES << req_ones);

    always_comb begin
        lowbit = cand_q & (~cand_q + WIDTH'(1));
        ripple = cand_q + lowbit;
        ctz    = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && cand_q[i]) begin
                ctz   = CW'(i);
                found = 1'b1;
            end
        end
        cand_d = ripple | (((cand_q ^ ripple) >> 2) >> ctz);
    end
`else
    assign seed = '0;

    always_comb begin
        cand_d = cand_q + WIDTH'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            cand_q      <= '0;
            req_ready_q <= 1'b1;
            req_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            req_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_ones > CW'(WIDTH)) begin
                            req_err_q <= 1'b1;
                        end else begin
                            target_q    <= req_ones;
                            cand_q      <= seed;
                            out_index_q <= '0;
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (popcnt(cand_q) == target_q) begin
                        out_data_q  <= cand_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (cand_q == last_pat);
                        state_q     <= HOLD;
                    end else begin
                        cand_q <= cand_q + WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            out_index_q <= out_index_q + WIDTH'(1);
                            cand_q      <= cand_d;
                            state_q     <= SCAN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;
endmodule
